mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Sequencing controller between the EX stage and the shared 32x32 iterative multiplier.
- Accepts MULT/MULTU/MUL/MADD/MADDU/MSUB/MSUBU requests from EX and drives the multiplier's start/annul handshake.
- Holds the pipeline stall while the multiplier runs, performs the HI/LO accumulate step, and issues one write-enable pulse per instruction.
- Handles pipeline flush by annulling the multiplier and draining it back to free before the next request.

Parameters:
- FLUSH_HOLD, 2: cycles annul is held high with start low after a flush; this guarantees the multiplier reaches its free state.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  EX holds a multiply-class instruction
- op_i  in  3  operation code (MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU)
- rs_data_i  in  32  operand 1
- rt_data_i  in  32  operand 2
- hilo_i  in  64  current {HI,LO}, already forwarded
- flush_i  in  1  pipeline flush
- mul_op1_o  out  32  multiplier operand 1
- mul_op2_o  out  32  multiplier operand 2
- mul_signed_o  out  1  signed multiply
- mul_start_o  out  1  multiplier start, level
- mul_annul_o  out  1  multiplier annul
- mul_result_i  in  64  multiplier product
- mul_ready_i  in  1  multiplier result ready
- stallreq_o  out  1  stall request to pipeline control
- hilo_we_o  out  1  HI/LO write-enable pulse
- hilo_wdata_o  out  64  HI/LO write data
- rd_we_o  out  1  GPR write-enable pulse (MUL only)
- rd_wdata_o  out  32  GPR write data (low product word)
- busy_o  out  1  state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; latched registers and flush counter cleared.
- Multiplier contract:
  - start is held high until ready.
  - Once ready is seen, start must drop; the multiplier then returns to free on the next cycle.
  - Annul is honoured only while the multiplier is computing.
- States: IDLE, MUL, ACC, DONE, FLUSH.
- IDLE:
  - On req_valid_i=1 and flush_i=0: latch op, operands and hilo_i.
  - mul_signed_o=1 for MULT/MUL/MADD/MSUB.
  - stallreq_o=1 combinationally in the same cycle. Next state is MUL.
- MUL:
  - mul_start_o=1; operands driven from the latches; stallreq_o=1.
  - On mul_ready_i=1: capture mul_result_i into prod. Next state is ACC for MADD/MADDU/MSUB/MSUBU, DONE otherwise.
- ACC (one cycle):
  - mul_start_o=0.
  - acc = hilo_latched + prod (MADD/MADDU) or hilo_latched - prod (MSUB/MSUBU).
  - 64-bit modular arithmetic, no overflow flag. stallreq_o=1. Next state is DONE.
- DONE (one cycle):
  - mul_start_o=0; stallreq_o=0.
  - MUL: rd_we_o=1, rd_wdata_o=prod[31:0], no HI/LO write.
  - MULT/MULTU: hilo_we_o=1, hilo_wdata_o=prod.
  - Accumulate ops: hilo_we_o=1, hilo_wdata_o=acc.
  - Next state is IDLE. A req_valid_i seen in the following IDLE cycle is a new instruction.
- Latency:
  - Nonzero operands: about 34 cycles in MUL, set by the multiplier.
  - Zero operand: about 2 cycles in MUL.
  - The controller adds 1 cycle (DONE) or 2 cycles (ACC+DONE).
- Flush:
  - flush_i=1 in MUL, ACC or DONE: no write pulses that cycle; mul_start_o=0, mul_annul_o=1; load the counter with FLUSH_HOLD-1; go to FLUSH.
  - flush_i=1 in IDLE with req_valid_i: the request is ignored.
- FLUSH:
  - mul_start_o=0, mul_annul_o=1, stallreq_o=0, requests ignored.
  - Counter decrements each cycle; go to IDLE when it reaches 0.
- Simultaneous mul_ready_i and flush_i in MUL: flush wins and the result is discarded.
- Undefined op_i code: treated as MULTU with no write (DONE pulses suppressed).

Decomposition:
- Op codes, state encodings, and Start/Stop levels go in defines.vh alongside the existing multiplier constants.
- No sub-module is needed. The accumulate adder stays inline.
- The multiplier is instantiated at the EX level, not inside mul_ctrl.

Test Plan:
- MULT rs=3, rt=0xFFFFFFFE:
  - stallreq_o high from the accept cycle until DONE.
  - Single hilo_we_o pulse with 0xFFFFFFFF_FFFFFFFA; rd_we_o never asserted.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hilo_wdata_o=0xFFFFFFFE_00000001.
- MUL 7 × 6 → rd_we_o pulse with rd_wdata_o=42; hilo_we_o stays 0.
- MADD hilo=10, rs=0, rt=5:
  - Zero-operand short path, MUL phase of 2 cycles or fewer.
  - hilo_wdata_o=10.
- MSUB hilo=0, 2×3 → hilo_wdata_o=0xFFFFFFFF_FFFFFFFA after the ACC cycle.
- Flush 10 cycles into a MULT:
  - mul_annul_o held for FLUSH_HOLD cycles; no write pulses.
  - A following MULTU 4×5 completes with 20.
- Async reset asserted mid-MUL: outputs go to 0 immediately; after release, an MULT 2×2 completes correctly.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// mul_ctrl_pkg: op codes, start/stop levels, FSM states and op-class helpers for mul_ctrl
package mul_ctrl_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_MADD  = 3'd3;
    localparam logic [2:0] OP_MADDU = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MSUBU = 3'd6;

    localparam logic MUL_START = 1'b1;
    localparam logic MUL_STOP  = 1'b0;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_ACC, S_DONE, S_FLUSH} state_e;

    function automatic logic op_signed(input logic [2:0] op);
        return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic op_acc(input logic [2:0] op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic op_sub(input logic [2:0] op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

    // Undefined codes fall outside every class, so they run as MULTU and never write.
    function automatic logic op_hilo(input logic [2:0] op);
        return op inside {OP_MULT, OP_MULTU} || op_acc(op);
    endfunction
endpackage

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences EX multiply-class ops through the shared iterative multiplier
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int FLUSH_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [63:0] hilo_i,
    input  logic        flush_i,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    output logic        mul_signed_o,
    output logic        mul_start_o,
    output logic        mul_annul_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [63:0] hilo_wdata_o,
    output logic        rd_we_o,
    output logic [31:0] rd_wdata_o,
    output logic        busy_o
);
    localparam int CW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   op1_q, op1_d, op2_q, op2_d;
    logic          sgn_q, sgn_d;
    logic [63:0]   hilo_q, hilo_d, prod_q, prod_d, acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, kill, done;

    assign accept = state_q == S_IDLE && req_valid_i && !flush_i;
    assign kill   = flush_i && state_q inside {S_MUL, S_ACC, S_DONE};
    assign done   = state_q == S_DONE && !flush_i;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sgn_d   = sgn_q;
        hilo_d  = hilo_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_i;
                    op1_d   = rs_data_i;
                    op2_d   = rt_data_i;
                    sgn_d   = op_signed(op_i);
                    hilo_d  = hilo_i;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_ready_i) begin
                    prod_d  = mul_result_i;
                    state_d = op_acc(op_q) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                acc_d   = op_sub(op_q) ? hilo_q - prod_q : hilo_q + prod_q;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_FLUSH: begin
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                state_d = (cnt_q > CW'(1)) ? S_FLUSH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A flush discards anything captured this cycle, including a coincident ready.
        if (kill) begin
            prod_d  = prod_q;
            acc_d   = acc_q;
            cnt_d   = CW'(FLUSH_HOLD - 1);
            state_d = S_FLUSH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sgn_q   <= 1'b0;
            hilo_q  <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sgn_q   <= sgn_d;
            hilo_q  <= hilo_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mul_op1_o    = op1_q;
    assign mul_op2_o    = op2_q;
    assign mul_signed_o = sgn_q;
    assign mul_start_o  = (state_q == S_MUL && !flush_i) ? MUL_START : MUL_STOP;
    assign mul_annul_o  = kill || state_q == S_FLUSH;
    assign stallreq_o   = !rst && (accept || (!flush_i && state_q inside {S_MUL, S_ACC}));
    assign hilo_we_o    = done && op_hilo(op_q);
    assign rd_we_o      = done && op_q == OP_MUL;
    assign hilo_wdata_o = op_acc(op_q) ? acc_q : prod_q;
    assign rd_wdata_o   = prod_q[31:0];
    assign busy_o       = state_q != S_IDLE;
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: randomized and directed checks of mul_ctrl against a transaction-level model
module tb_mul_ctrl;
    localparam int FLUSH_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs_data_i = '0, rt_data_i = '0;
    logic [63:0] hilo_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] mul_op1_o, mul_op2_o;
    logic        mul_signed_o, mul_start_o, mul_annul_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;
    logic        stallreq_o, hilo_we_o, rd_we_o, busy_o;
    logic [63:0] hilo_wdata_o;
    logic [31:0] rd_wdata_o;

    mul_ctrl #(.FLUSH_HOLD(FLUSH_HOLD)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .op_i(op_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .hilo_i(hilo_i), .flush_i(flush_i),
        .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o), .mul_signed_o(mul_signed_o),
        .mul_start_o(mul_start_o), .mul_annul_o(mul_annul_o),
        .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
        .stallreq_o(stallreq_o), .hilo_we_o(hilo_we_o), .hilo_wdata_o(hilo_wdata_o),
        .rd_we_o(rd_we_o), .rd_wdata_o(rd_wdata_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    endtask

    function automatic logic [63:0] prod64(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return s ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic ref_signed(input logic [2:0] op);
        return op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd5;
    endfunction

    // Iterative multiplier: ready after 2 cycles of start for a zero operand, 34 otherwise.
    logic        m_busy = 1'b0, m_ready = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_res = '0;

    assign mul_ready_i  = m_ready;
    assign mul_result_i = m_ready ? m_res : 64'hDEAD_BEEF_0BAD_F00D;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_cnt <= 0; m_res <= '0;
        end else if (m_busy && m_ready) begin
            if (!mul_start_o) begin m_busy <= 1'b0; m_ready <= 1'b0; end
        end else if (m_busy) begin
            if (mul_annul_o) m_busy <= 1'b0;
            else if (m_cnt == 0) m_ready <= 1'b1;
            else m_cnt <= m_cnt - 1;
        end else if (mul_start_o && !mul_annul_o) begin
            m_busy  <= 1'b1;
            m_ready <= (mul_op1_o == 0 || mul_op2_o == 0);
            m_cnt   <= 31;
            m_res   <= prod64(mul_signed_o, mul_op1_o, mul_op2_o);
        end
    end

    // Transaction-level model of the controller, checked every cycle.
    logic        exp_active = 1'b0, exp_sgn = 1'b0, in_flush;
    int          annul_left = 0, cyc = 0, exp_len = 0, exp_kind = 0;
    logic [63:0] exp_data = '0, p;
    logic [31:0] exp_a = '0, exp_b = '0;
    int          last_kind = 0, last_cyc = 0, n_writes = 0, annul_cnt = 0;
    logic [63:0] last_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctl", {stallreq_o, mul_start_o, mul_annul_o, hilo_we_o, rd_we_o, busy_o}, 0);
            chk("reset_wdata", hilo_wdata_o, 0);
            exp_active = 1'b0;
            annul_left = 0;
        end else begin
            in_flush = annul_left > 0;
            if (mul_annul_o) annul_cnt++;
            n_writes += int'(hilo_we_o) + int'(rd_we_o);
            chk("annul", mul_annul_o, in_flush || (flush_i && exp_active));
            chk("busy", busy_o, exp_active || in_flush);
            if (m_busy && !m_ready && !mul_annul_o) chk("start_held", mul_start_o, 1);
            if (exp_active && flush_i) begin
                chk("flush_cycle", {stallreq_o, hilo_we_o, rd_we_o, mul_start_o}, 0);
                exp_active = 1'b0;
                annul_left = FLUSH_HOLD - 1;
            end else begin
                if (in_flush) annul_left--;
                if (!exp_active && !in_flush && req_valid_i && !flush_i) begin
                    exp_a   = rs_data_i;
                    exp_b   = rt_data_i;
                    exp_sgn = ref_signed(op_i);
                    p       = prod64(exp_sgn, exp_a, exp_b);
                    exp_len = ((exp_a == 0 || exp_b == 0) ? 2 : 34) + 2 + ((op_i >= 3 && op_i <= 6) ? 1 : 0);
                    case (op_i)
                        3'd0, 3'd1: begin exp_kind = 1; exp_data = p; end
                        3'd2:       begin exp_kind = 2; exp_data = {32'b0, p[31:0]}; end
                        3'd3, 3'd4: begin exp_kind = 1; exp_data = hilo_i + p; end
                        3'd5, 3'd6: begin exp_kind = 1; exp_data = hilo_i - p; end
                        default:    begin exp_kind = 0; exp_data = '0; end
                    endcase
                    exp_active = 1'b1;
                    cyc = 0;
                end
                if (exp_active) begin
                    cyc++;
                    if (mul_start_o) begin
                        chk("mul_operands", {mul_op1_o, mul_op2_o}, {exp_a, exp_b});
                        chk("mul_signed", mul_signed_o, exp_sgn);
                    end
                    if (stallreq_o) chk("no_early_write", {hilo_we_o, rd_we_o}, 0);
                    else begin
                        chk("write_enables", {hilo_we_o, rd_we_o}, exp_kind == 1 ? 2'b10 : exp_kind == 2 ? 2'b01 : 2'b00);
                        if (exp_kind == 1) chk("hilo_wdata", hilo_wdata_o, exp_data);
                        if (exp_kind == 2) chk("rd_wdata", {32'b0, rd_wdata_o}, exp_data);
                        chk("latency", cyc, exp_len);
                        last_kind  = hilo_we_o ? 1 : rd_we_o ? 2 : 0;
                        last_data  = hilo_we_o ? hilo_wdata_o : {32'b0, rd_wdata_o};
                        last_cyc   = cyc;
                        exp_active = 1'b0;
                    end
                end else chk("idle_quiet", {stallreq_o, hilo_we_o, rd_we_o, mul_start_o}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] h, input int flush_at);
        int n;
        tick();
        op_i = op; rs_data_i = a; rt_data_i = b; hilo_i = h; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        n = 1;
        while ((exp_active || annul_left > 0 || flush_i) && n < 300) begin
            flush_i = (n == flush_at) && exp_active;
            tick();
            n++;
        end
        flush_i = 1'b0;
        if (n >= 300) chk("op_timeout", 1, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, a0;
        #1;
        chk("init_reset", {stallreq_o, busy_o, hilo_we_o, rd_we_o, mul_start_o, mul_annul_o}, 0);
        tick(); tick();
        rst = 1'b0;

        do_op(3'd0, 32'd3, 32'hFFFF_FFFE, 64'd0, 0);
        chk("mult_kind", last_kind, 1);
        chk("mult_value", last_data, 64'hFFFF_FFFF_FFFF_FFFA);

        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 0);
        chk("multu_value", last_data, 64'hFFFF_FFFE_0000_0001);

        do_op(3'd2, 32'd7, 32'd6, 64'h1234, 0);
        chk("mul_kind", last_kind, 2);
        chk("mul_value", last_data, 64'd42);

        do_op(3'd3, 32'd0, 32'd5, 64'd10, 0);
        chk("madd_value", last_data, 64'd10);
        chk("madd_short_latency", last_cyc, 5);

        do_op(3'd5, 32'd2, 32'd3, 64'd0, 0);
        chk("msub_value", last_data, 64'hFFFF_FFFF_FFFF_FFFA);

        w0 = n_writes; a0 = annul_cnt;
        do_op(3'd0, 32'd9, 32'd11, 64'd0, 10);
        chk("flush_no_write", n_writes - w0, 0);
        chk("flush_annul_cycles", annul_cnt - a0, 2);
        do_op(3'd1, 32'd4, 32'd5, 64'd0, 0);
        chk("after_flush_value", last_data, 64'd20);

        w0 = n_writes;
        do_op(3'd7, 32'd3, 32'd4, 64'd0, 0);
        chk("undef_no_write", n_writes - w0, 0);

        tick();
        op_i = 3'd0; rs_data_i = 32'd5; rt_data_i = 32'd5; req_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        req_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("idle_flush_ignored", busy_o, 0);

        tick();
        op_i = 3'd0; rs_data_i = 32'd5; rt_data_i = 32'd7; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_reset_ctl", {stallreq_o, mul_start_o, mul_annul_o, hilo_we_o, rd_we_o, busy_o}, 0);
        chk("async_reset_ops", {mul_op1_o, mul_op2_o}, 0);
        tick(); tick();
        rst = 1'b0;
        do_op(3'd0, 32'd2, 32'd2, 64'd0, 0);
        chk("after_reset_value", last_data, 64'd4);

        for (int i = 0; i < 60; i++)
            do_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), {$urandom, $urandom},
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 38)) : 0);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
